// File: rtl/buzzer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_scheduler
// Purpose  : Shares one Buzzer tune player between N_REQ requesters.
//            Grants by fixed priority (index 0 highest), drives song_sel to
//            the ROM base-address logic, and sequences the Buzzer through its
//            enable port (1 = restart/mute, 0 = play). It watches buz_done
//            and returns a one-cycle ack to the requester. It also aborts a
//            tune on preemption, timeout or request withdrawal.
// Ports    : clk_i        system clock
//            reset_i      asynchronous reset, active-high
//            req_i        level requests; held until ack, then dropped
//            ack_o        one-hot pulse, the granted tune has ended
//            aborted_o    valid with ack_o; 1 = preempted or timed out
//            busy_o       high whenever the scheduler is not idle
//            song_sel_o   index of the granted requester
//            buz_enable_o Buzzer enable (1 = restart/mute)
//            buz_done_i   Buzzer done
// Revision : 1.0  initial release
// ============================================================================
module buzzer_scheduler #(
  parameter int          N_REQ       = 4,
  parameter int          SONG_W      = 2,
  parameter int          START_CYC   = 2,
  parameter logic [31:0] TIMEOUT_CYC = 32'd200000,
  parameter int          PREEMPT     = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [N_REQ-1:0]  req_i,
  output logic [N_REQ-1:0]  ack_o,
  output logic              aborted_o,
  output logic              busy_o,
  output logic [SONG_W-1:0] song_sel_o,
  output logic              buz_enable_o,
  input  logic              buz_done_i
);

  localparam int               CNT_W          = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [CNT_W-1:0] C_START_LAST   = CNT_W'(START_CYC - 1);
  localparam logic [31:0]      C_TIMEOUT_LAST = TIMEOUT_CYC - 32'd1;
  localparam logic             C_TIMEOUT_EN   = (TIMEOUT_CYC != 32'd0);
  localparam logic             C_PREEMPT_EN   = (PREEMPT != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_ARM    = 3'd2,
    S_PLAY   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         timer_q;
  logic [31:0]         timer_d;
  logic [SONG_W-1:0]   song_sel_q;
  logic [N_REQ-1:0]    ack_q;
  logic                aborted_q;
  logic                busy_q;
  logic                buz_enable_q;

  logic [SONG_W-1:0]   w_grant;
  logic [N_REQ-1:0]    w_onehot;
  logic                w_higher;
  logic                w_withdraw;
  logic                w_preempt;
  logic                w_timeout;

  always_comb begin
    // Lowest set index wins: scan from the top so the last hit is the lowest.
    w_grant = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) w_grant = SONG_W'(i);
    end
    w_onehot = '0;
    w_higher = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (song_sel_q == SONG_W'(i)) w_onehot[i] = 1'b1;
      if (SONG_W'(i) < song_sel_q)  w_higher    = w_higher | req_i[i];
    end
    w_withdraw = ~|(req_i & w_onehot);
    w_preempt  = C_PREEMPT_EN & w_higher;
    w_timeout  = C_TIMEOUT_EN & (timer_q == C_TIMEOUT_LAST);
    // Saturating increment so a disabled timeout can never wrap into a match.
    timer_d    = (&timer_q) ? timer_q : timer_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      song_sel_q   <= '0;
      ack_q        <= '0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      buz_enable_q <= 1'b1;
    end else begin
      ack_q     <= '0;
      aborted_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          buz_enable_q <= 1'b1;
          busy_q       <= 1'b0;
          timer_q      <= '0;
          if (|req_i) begin
            state_q    <= S_START;
            busy_q     <= 1'b1;
            song_sel_q <= w_grant;
            cnt_q      <= '0;
          end
        end

        S_START, S_ARM, S_PLAY: begin
          // Event precedence: withdrawal > done > preempt > timeout.
          if (w_withdraw) begin
            state_q      <= S_FINISH;
            buz_enable_q <= 1'b1;
          end else if ((state_q == S_PLAY) && buz_done_i) begin
            state_q      <= S_FINISH;
            buz_enable_q <= 1'b1;
            ack_q        <= w_onehot;
          end else if (w_preempt || ((state_q != S_START) && w_timeout)) begin
            state_q      <= S_FINISH;
            buz_enable_q <= 1'b1;
            ack_q        <= w_onehot;
            aborted_q    <= 1'b1;
          end else if (state_q == S_START) begin
            if (cnt_q == C_START_LAST) begin
              state_q      <= S_ARM;
              buz_enable_q <= 1'b0;
              timer_q      <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            timer_q <= timer_d;
            // A done still high from the previous tune is ignored until it drops.
            if ((state_q == S_ARM) && !buz_done_i) state_q <= S_PLAY;
          end
        end

        S_FINISH: begin
          state_q      <= S_IDLE;
          buz_enable_q <= 1'b1;
          busy_q       <= 1'b0;
        end

        default: begin
          state_q      <= S_IDLE;
          buz_enable_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o        = ack_q;
  assign aborted_o    = aborted_q;
  assign busy_o       = busy_q;
  assign song_sel_o   = song_sel_q;
  assign buz_enable_o = buz_enable_q;

endmodule
`default_nettype wire
